// File: rtl/sram_bus_master_pkg.sv
// Shared definitions for the SRAM initiator: state encoding, inactive pin levels
// and the default access timing also used by the CPU-side SRAM path.
package sram_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic WE_INACTIVE  = 1'b1;
  localparam logic RE_INACTIVE  = 1'b1;
  localparam logic CE_INACTIVE  = 1'b1;
  localparam logic CE2_INACTIVE = 1'b0;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Counter width large enough to hold the longest phase length.
  function automatic int phase_cnt_w(input int s, input int p, input int h);
    int m;
    m = (s > p) ? s : p;
    m = (m > h) ? m : h;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times one access phase; o_tc flags the last
// clock of the phase.
module sram_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sram_bus_master.sv
// Sequences single-word read/write cycles on the external asynchronous SRAM
// for an internal client while the CPU is held off the bus.
module sram_bus_master
  import sram_bus_master_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_grant,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_oe,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_WE,
  output logic              o_RE,
  output logic              o_CE,
  output logic              o_CE2
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t             r_state;
  logic               r_write;
  logic               r_ack;
  logic               r_busy;
  logic [DATA_W-1:0]  r_rdata;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_data_oe;
  logic               r_we_n;
  logic               r_re_n;
  logic               r_ce_n;
  logic               r_ce2;

  logic               w_accept;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_tc;

  // The timer is reloaded on every phase entry with (phase length - 1).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && i_req && i_grant;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_load     = 1'b1;
        w_load_val = (SETUP_CYC > 0) ? LD_SETUP : LD_PULSE;
      end
      ST_SETUP: if (w_tc) begin
        w_load     = 1'b1;
        w_load_val = LD_PULSE;
      end
      ST_PULSE: if (w_tc && (HOLD_CYC > 0)) begin
        w_load     = 1'b1;
        w_load_val = LD_HOLD;
      end
      default: ;
    endcase
  end

  sram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_data_oe <= 1'b0;
      r_we_n    <= WE_INACTIVE;
      r_re_n    <= RE_INACTIVE;
      r_ce_n    <= CE_INACTIVE;
      r_ce2     <= CE2_INACTIVE;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_write <= i_write;
          r_addr  <= i_addr;
          r_busy  <= 1'b1;
          r_ce_n  <= ~CE_INACTIVE;
          r_ce2   <= ~CE2_INACTIVE;
          if (i_write) begin
            r_data    <= i_wdata;
            r_data_oe <= 1'b1;
          end
          // With no setup phase the strobe starts together with chip enable.
          if (SETUP_CYC == 0) begin
            r_state <= ST_PULSE;
            if (i_write) r_we_n <= ~WE_INACTIVE;
            else         r_re_n <= ~RE_INACTIVE;
          end else begin
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: if (w_tc) begin
          r_state <= ST_PULSE;
          if (r_write) r_we_n <= ~WE_INACTIVE;
          else         r_re_n <= ~RE_INACTIVE;
        end
        ST_PULSE: if (w_tc) begin
          // Read data is captured while the output enable is still low.
          if (!r_write) r_rdata <= i_data;
          r_we_n  <= WE_INACTIVE;
          r_re_n  <= RE_INACTIVE;
          r_state <= (HOLD_CYC > 0) ? ST_HOLD : ST_DONE;
        end
        ST_HOLD: if (w_tc) begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_ack     <= 1'b1;
          r_busy    <= 1'b0;
          r_ce_n    <= CE_INACTIVE;
          r_ce2     <= CE2_INACTIVE;
          r_data_oe <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack     = r_ack;
  assign o_busy    = r_busy;
  assign o_rdata   = r_rdata;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_data_oe = r_data_oe;
  assign o_WE      = r_we_n;
  assign o_RE      = r_re_n;
  assign o_CE      = r_ce_n;
  assign o_CE2     = r_ce2;

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: a default-timing instance and a minimal-timing
// instance, both compared every cycle against a cycles-since-accept model.
module tb_sram_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req[2], grant[2], wr[2];
  logic [14:0] addr[2];
  logic [7:0]  wdata[2];
  logic        ack[2], busy[2], oe[2], we_n[2], re_n[2], ce_n[2], ce2[2];
  logic [14:0] sa[2];
  logic [7:0]  sd[2], rdata[2], idata[2];
  logic [7:0]  mem [0:32767];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: clocks since accept (-1 = idle) plus latched fields.
  int          m_t[2] = '{-1, -1};
  logic        m_wr[2];
  logic [14:0] m_addr[2];
  logic [7:0]  m_data[2], m_rdata[2];

  int ce_lo[2], we_lo[2], re_lo[2], we_first[2], ack_n[2], ack_last[2];
  int ack_q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_bus_master u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_grant(grant[0]), .i_req(req[0]), .i_write(wr[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .o_ack(ack[0]), .o_busy(busy[0]),
    .o_rdata(rdata[0]), .o_addr(sa[0]), .o_data(sd[0]), .o_data_oe(oe[0]),
    .i_data(idata[0]), .o_WE(we_n[0]), .o_RE(re_n[0]), .o_CE(ce_n[0]), .o_CE2(ce2[0])
  );

  sram_bus_master #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_grant(grant[1]), .i_req(req[1]), .i_write(wr[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .o_ack(ack[1]), .o_busy(busy[1]),
    .o_rdata(rdata[1]), .o_addr(sa[1]), .o_data(sd[1]), .o_data_oe(oe[1]),
    .i_data(idata[1]), .o_WE(we_n[1]), .o_RE(re_n[1]), .o_CE(ce_n[1]), .o_CE2(ce2[1])
  );

  // Instance 0 talks to an SRAM array; instance 1 sees a fixed address pattern.
  assign idata[0] = mem[sa[0]];
  assign idata[1] = sa[1][7:0] ^ 8'h5A;
  always @(posedge clk) if (!we_n[0] && !ce_n[0]) mem[sa[0]] = sd[0];

  function automatic int sc(input int k); return (k == 0) ? 1 : 0; endfunction
  function automatic int pc(input int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int hc(input int k); return (k == 0) ? 1 : 0; endfunction
  function automatic int lat(input int k); return sc(k) + pc(k) + hc(k) + 1; endfunction

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, got, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_t[k] <= -1; m_wr[k] <= 1'b0; m_addr[k] <= '0; m_data[k] <= '0; m_rdata[k] <= '0;
      end else if (m_t[k] < 0 || m_t[k] == lat(k)) begin
        if (req[k] && grant[k]) begin
          m_t[k] <= 0; m_wr[k] <= wr[k]; m_addr[k] <= addr[k];
          if (wr[k]) m_data[k] <= wdata[k];
        end else begin
          m_t[k] <= -1;
        end
      end else begin
        if (!m_wr[k] && m_t[k] == sc(k) + pc(k) - 1) m_rdata[k] <= idata[k];
        m_t[k] <= m_t[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit b, s;
      b = (m_t[k] >= 0) && (m_t[k] < lat(k));
      s = b && (m_t[k] >= sc(k)) && (m_t[k] < sc(k) + pc(k));
      check("ack",   k, 32'(ack[k]),  32'(m_t[k] == lat(k)));
      check("busy",  k, 32'(busy[k]), 32'(b));
      check("ce_n",  k, 32'(ce_n[k]), 32'(!b));
      check("ce2",   k, 32'(ce2[k]),  32'(b));
      check("we_n",  k, 32'(we_n[k]), 32'(!(s && m_wr[k])));
      check("re_n",  k, 32'(re_n[k]), 32'(!(s && !m_wr[k])));
      check("oe",    k, 32'(oe[k]),   32'(b && m_wr[k]));
      check("addr",  k, 32'(sa[k]),   32'(m_addr[k]));
      check("data",  k, 32'(sd[k]),   32'(m_data[k]));
      check("rdata", k, 32'(rdata[k]), 32'(m_rdata[k]));
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!ce_n[k]) ce_lo[k]++;
      if (!we_n[k]) begin
        if (we_lo[k] == 0) we_first[k] = cyc;
        we_lo[k]++;
      end
      if (!re_n[k]) re_lo[k]++;
      if (ack[k]) begin
        ack_n[k]++;
        ack_last[k] = cyc;
        if (k == 0) ack_q0.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      ce_lo[k] = 0; we_lo[k] = 0; re_lo[k] = 0; we_first[k] = -1;
    end
    ack_q0.delete();
  endtask

  task automatic wait_acks(input int k, input int target, input int budget);
    int i = 0;
    while (ack_n[k] < target && i < budget) begin
      step(1);
      i++;
    end
    check("ack_wait", k, 32'(ack_n[k] >= target), 32'd1);
  endtask

  task automatic txn(input int k, input logic w, input logic [14:0] a, input logic [7:0] d,
                     output int acc);
    int n0;
    n0 = ack_n[k];
    wr[k] = w; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    acc = cyc + 1;
    wait_acks(k, n0 + 1, 30);
    req[k] = 1'b0;
  endtask

  initial begin
    int acc, n0;
    for (int i = 0; i < 32768; i++) mem[i] = 8'(i) ^ 8'hC3;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; grant[k] = 1'b1; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      ack_n[k] = 0; ack_last[k] = 0;
    end
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_ce_n", 0, 32'(ce_n[0]), 32'd1);
    check("rst_we_n", 0, 32'(we_n[0]), 32'd1);
    check("rst_re_n", 0, 32'(re_n[0]), 32'd1);
    check("rst_ce2",  0, 32'(ce2[0]),  32'd0);
    check("rst_busy", 0, 32'(busy[0]), 32'd0);

    clr();
    txn(0, 1'b1, 15'h1234, 8'hA5, acc);
    check("wr_latency",  0, 32'(ack_last[0] - acc), 32'd5);
    check("wr_ce_low",   0, 32'(ce_lo[0]), 32'd5);
    check("wr_we_low",   0, 32'(we_lo[0]), 32'd2);
    check("wr_we_start", 0, 32'(we_first[0] - acc), 32'd1);
    check("wr_re_low",   0, 32'(re_lo[0]), 32'd0);
    check("wr_data",     0, 32'(sd[0]), 32'hA5);

    mem[15'h7FFF] = 8'h3C;
    clr();
    txn(0, 1'b0, 15'h7FFF, 8'h00, acc);
    check("rd_latency", 0, 32'(ack_last[0] - acc), 32'd5);
    check("rd_re_low",  0, 32'(re_lo[0]), 32'd2);
    check("rd_we_low",  0, 32'(we_lo[0]), 32'd0);
    check("rd_rdata",   0, 32'(rdata[0]), 32'h3C);

    clr();
    n0 = ack_n[0];
    wr[0] = 1'b1; addr[0] = 15'h0100; wdata[0] = 8'h11; req[0] = 1'b1;
    wait_acks(0, n0 + 3, 40);
    req[0] = 1'b0;
    check("b2b_acks", 0, 32'(ack_q0.size()), 32'd3);
    if (ack_q0.size() >= 3) begin
      check("b2b_gap1", 0, 32'(ack_q0[1] - ack_q0[0]), 32'd6);
      check("b2b_gap2", 0, 32'(ack_q0[2] - ack_q0[1]), 32'd6);
    end
    check("b2b_ce_low", 0, 32'(ce_lo[0]), 32'd15);

    clr();
    n0 = ack_n[0];
    grant[0] = 1'b0; wr[0] = 1'b1; addr[0] = 15'h2222; wdata[0] = 8'h5C; req[0] = 1'b1;
    step(20);
    check("nogrant_ce", 0, 32'(ce_lo[0]), 32'd0);
    check("nogrant_ack", 0, 32'(ack_n[0] - n0), 32'd0);
    grant[0] = 1'b1;
    acc = cyc + 1;
    wait_acks(0, n0 + 1, 30);
    req[0] = 1'b0;
    check("grant_latency", 0, 32'(ack_last[0] - acc), 32'd5);

    n0 = ack_n[0];
    wr[0] = 1'b0; addr[0] = 15'h0042; req[0] = 1'b1;
    acc = cyc + 1;
    step(2);
    grant[0] = 1'b0;
    wait_acks(0, n0 + 1, 30);
    req[0] = 1'b0;
    grant[0] = 1'b1;
    check("grant_drop_latency", 0, 32'(ack_last[0] - acc), 32'd5);

    clr();
    n0 = ack_n[0];
    wr[0] = 1'b1; addr[0] = 15'h0555; wdata[0] = 8'h77; req[0] = 1'b1;
    step(2);
    check("pulse_we_low", 0, 32'(we_n[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_we_n", 0, 32'(we_n[0]), 32'd1);
    check("async_ce_n", 0, 32'(ce_n[0]), 32'd1);
    check("async_oe",   0, 32'(oe[0]),   32'd0);
    check("async_ack",  0, 32'(ack[0]),  32'd0);
    req[0] = 1'b0;
    step(1);
    rst = 1'b0;
    step(10);
    check("reset_no_ack", 0, 32'(ack_n[0] - n0), 32'd0);
    txn(0, 1'b1, 15'h0555, 8'h78, acc);
    check("post_reset_latency", 0, 32'(ack_last[0] - acc), 32'd5);

    clr();
    txn(1, 1'b1, 15'h0033, 8'hE1, acc);
    check("fast_wr_latency", 1, 32'(ack_last[1] - acc), 32'd2);
    check("fast_we_low",     1, 32'(we_lo[1]), 32'd1);
    check("fast_we_start",   1, 32'(we_first[1] - acc), 32'd0);
    check("fast_ce_low",     1, 32'(ce_lo[1]), 32'd2);
    clr();
    txn(1, 1'b0, 15'h00F0, 8'h00, acc);
    check("fast_rd_latency", 1, 32'(ack_last[1] - acc), 32'd2);
    check("fast_re_low",     1, 32'(re_lo[1]), 32'd1);
    check("fast_rdata",      1, 32'(rdata[1]), 32'hAA);

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        req[k]   = ($urandom_range(0, 3) != 0);
        grant[k] = ($urandom_range(0, 7) != 0);
        wr[k]    = 1'($urandom_range(0, 1));
        addr[k]  = 15'($urandom);
        wdata[k] = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step(1);
    end
    for (int k = 0; k < 2; k++) req[k] = 1'b0;
    step(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
